pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the single-cycle RISC-V core. Drives data_in/Write_enable of the PC register.
//  Reads PC data_out back on pc_current. Selects among sequential, branch, jump, trap and mret targets.
//  Runs a boot/run/halt/trap FSM and holds epc/mcause for trap return.
//  The PC register has no reset of its own, so this block loads the reset vector after reset.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded during BOOT
//  TRAP_VECTOR   32'h0000_0100  PC loaded on trap entry
//  BOOT_CYCLES   2              cycles spent in BOOT (>=1)
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   asynchronous, active-high reset
//  pc_current    in   32  PC register data_out
//  stall         in   1   hold PC this cycle
//  branch_taken  in   1   conditional branch resolved taken
//  branch_target in   32  branch destination
//  jump          in   1   jal/jalr
//  jump_target   in   32  jump destination
//  trap_req      in   1   ecall/illegal/external trap request
//  trap_cause    in   4   cause code for trap_req
//  mret          in   1   return from trap
//  halt_req      in   1   ebreak-style halt
//  resume        in   1   leave HALT
//  pc_next       out  32  to PC data_in
//  pc_we         out  1   to PC Write_enable
//  flush         out  1   redirect taken this cycle
//  epc           out  32  saved trap PC
//  mcause        out  4   saved trap cause
//  halted        out  1   FSM in HALT
// BEHAVIOUR
//  - Reset (async): state=BOOT, boot_cnt=0, epc=0, mcause=0. While rst=1: pc_we=0, flush=0, pc_next=RESET_VECTOR, halted=0.
//  - pc_next, pc_we and flush are combinational (Mealy) from state and inputs.
//  - epc, mcause, state and boot_cnt update on the clk rising edge.
//  - BOOT: pc_next=RESET_VECTOR, pc_we=1, other inputs ignored.
//    boot_cnt increments each cycle; after BOOT_CYCLES cycles -> RUN.
//  - RUN, fixed priority, first match wins:
//    1 trap_req -> pc_next=TRAP_VECTOR, pc_we=1, flush=1; epc<=pc_current, mcause<=trap_cause; -> TRAP.
//    2 mret -> pc_next=epc, pc_we=1, flush=1.
//    3 jump -> pc_next=jump_target, pc_we=1, flush=1.
//    4 branch_taken -> pc_next=branch_target, pc_we=1, flush=1.
//    5 halt_req -> pc_we=0; -> HALT.
//    6 stall -> pc_we=0, pc_next=pc_current.
//    7 default -> pc_next=pc_current+4, pc_we=1. 32-bit add wraps: 0xFFFF_FFFC -> 0x0000_0000.
//  - Misaligned redirect: if a selected mret/jump/branch target has [1:0]!=0, take it as a trap instead.
//    Trap response: pc_next=TRAP_VECTOR, flush=1, mcause<=4'd0, epc<=pc_current; -> TRAP.
//  - Trap and redirects override stall; stall only blocks sequential advance and halt entry.
//  - TRAP: one-cycle flush bubble. pc_we=0, flush=1, inputs ignored; -> RUN.
//  - HALT: pc_we=0, halted=1, trap_req/jump/branch ignored.
//    resume=1 -> RUN on the next edge; PC resumes at pc_current (no skip).
//  - Reset asserted in any state aborts immediately to BOOT; no partial epc update.
// TESTING
//  - Reset release, RESET_VECTOR=0, BOOT_CYCLES=2: pc_we=1/pc_next=0 for 2 cycles.
//    Then sequential 0,4,8,0xC on successive edges.
//  - pc_current=0x10, branch_taken=1, branch_target=0x40 -> pc_next=0x40, flush=1.
//    Same cycle with stall=1 -> still 0x40.
//  - pc_current=0x20, trap_req=1, trap_cause=4'hB -> pc_next=0x100, epc=0x20, mcause=0xB.
//    Next cycle flush=1, pc_we=0; later mret -> pc_next=0x20.
//  - jump=1, jump_target=0x42 -> pc_next=0x100, mcause=0, epc=pc_current.
//    jump+trap_req together -> trap wins with trap_cause.
//  - halt_req at pc 0x30 -> halted=1, pc_we=0 for 5 cycles with branch_taken pulsed.
//    resume -> pc_next=0x34 next cycle.
//  - pc_current=0xFFFF_FFFC free-run -> pc_next=0.
//    rst pulse mid-HALT -> halted=0, epc=0, BOOT re-entered.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot/run/halt/trap sequencing for the single-cycle core.
// Drives the PC register write port and keeps epc/mcause for trap return.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          BOOT_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_current,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap_req,
    input  logic [3:0]  trap_cause,
    input  logic        mret,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic        pc_we,
    output logic        flush,
    output logic [31:0] epc,
    output logic [3:0]  mcause,
    output logic        halted
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_TRAP = 2'd3;

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] boot_cnt;
    logic          redir;
    logic [31:0]   redir_tgt;
    logic          take_trap;
    logic [3:0]    trap_code;

    assign redir  = mret | jump | branch_taken;
    assign halted = (state == S_HALT);

    always_comb begin
        if (mret)
            redir_tgt = epc;
        else if (jump)
            redir_tgt = jump_target;
        else
            redir_tgt = branch_target;
    end

    always_comb begin
        pc_next   = pc_current;
        pc_we     = 1'b0;
        flush     = 1'b0;
        state_nxt = state;
        take_trap = 1'b0;
        trap_code = trap_cause;
        unique case (state)
            S_BOOT: begin
                pc_next = RESET_VECTOR;
                pc_we   = 1'b1;
                if (boot_cnt == BOOT_LAST)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                // redirects and traps win over stall; stall only holds
                if (trap_req) begin
                    take_trap = 1'b1;
                end else if (redir) begin
                    if (redir_tgt[1:0] != 2'b00) begin
                        take_trap = 1'b1;
                        trap_code = 4'd0;
                    end else begin
                        pc_next = redir_tgt;
                        pc_we   = 1'b1;
                        flush   = 1'b1;
                    end
                end else if (halt_req && !stall) begin
                    state_nxt = S_HALT;
                end else if (!stall) begin
                    pc_next = pc_current + 32'd4;
                    pc_we   = 1'b1;
                end
            end
            S_HALT: begin
                if (resume)
                    state_nxt = S_RUN;
            end
            S_TRAP: begin
                flush     = 1'b1;
                state_nxt = S_RUN;
            end
            default: state_nxt = S_BOOT;
        endcase
        if (take_trap) begin
            pc_next   = TRAP_VECTOR;
            pc_we     = 1'b1;
            flush     = 1'b1;
            state_nxt = S_TRAP;
        end
        if (rst) begin
            pc_next = RESET_VECTOR;
            pc_we   = 1'b0;
            flush   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_BOOT;
            boot_cnt <= '0;
            epc      <= 32'd0;
            mcause   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == S_BOOT && state_nxt == S_BOOT)
                boot_cnt <= boot_cnt + 1'b1;
            else
                boot_cnt <= '0;
            if (take_trap) begin
                epc    <= pc_current;
                mcause <= trap_code;
            end
        end
    end

endmodule
